uart_rx_packer: RTL and testbench
=================================

# uart_rx_packer

Parametrised UART receiver and word packer feeding the matrix-vector multiplier input bus. It samples the asynchronous `rx` pin at mid-bit and supports configurable parity, stop bits and bus width. Received bytes are assembled into one `W_OUT`-bit packet, delivered on a valid/ready handshake with backpressure, and framing, parity, overflow and timeout conditions are reported. It replaces the fixed 8N1 receiver in front of the MVM core; the input is `ui_in[0]` and the output is the K/X bus.

## Interface
- `CLOCKS_PER_PULSE`, 32, clock cycles per UART bit; must be ≥ 4 and even.
- `BITS_PER_WORD`, 8, data bits per UART frame (5..9).
- `W_OUT`, 24, output bus width; must be a multiple of `BITS_PER_WORD`. `N_WORDS = W_OUT/BITS_PER_WORD`.
- `PARITY`, `PAR_NONE`, one of `PAR_NONE`, `PAR_ODD` or `PAR_EVEN`.
- `STOP_BITS`, 1, number of stop bits (1 or 2).
- `TIMEOUT_PULSES`, 0, idle bit-times before a partial packet is discarded; 0 disables the timeout.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial line, idle high.
- `m_data` out `W_OUT`: packet. Word i occupies `[i*BITS_PER_WORD +: BITS_PER_WORD]`; word 0 is the first received. Bits within a word are LSB-first on the line.
- `m_valid` out 1: packet available.
- `m_ready` in 1: consumer accepts the packet.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `parity_err` out 1: one-cycle pulse on parity mismatch.
- `overflow` out 1: one-cycle pulse when a packet is dropped because the output register is full.
- `busy` out 1: high while the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. All decisions use `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. A bit-period counter `pcnt` runs from 0 to `CLOCKS_PER_PULSE-1`.
- **IDLE:** when `rx_s==0`, go to START and set `pcnt=0`.
- **START:** sample at `pcnt==CLOCKS_PER_PULSE/2-1`. If `rx_s==1`, treat it as a glitch and return to IDLE with no error. Otherwise go to DATA. Every later sample is taken `CLOCKS_PER_PULSE` cycles after the previous one.
- **DATA:** take `BITS_PER_WORD` samples, shifted into the word LSB-first. Then go to PARITY if `PARITY!=PAR_NONE`, else to STOP.
- **PARITY:** odd parity requires XOR(data, p) = 1; even parity requires XOR(data, p) = 0. A mismatch raises a `parity_err` pulse and marks the word bad. Then go to STOP.
- **STOP:** take `STOP_BITS` samples.
  - Any low sample raises `frame_err`, discards the whole partial packet (word counter reset to 0) and goes to BREAK.
  - Otherwise, a bad word discards the partial packet and the FSM returns to IDLE.
  - Otherwise the good word is written to slot `wcnt`, `wcnt` increments, and the FSM returns to IDLE.
- **BREAK:** wait for `rx_s==1`, then go to IDLE. This stops a held-low line from re-triggering reception.
- **Packet completion:** when `wcnt` reaches `N_WORDS`, the assembly buffer is copied to `m_data` and `m_valid` is set.
  - If `m_valid` is already high and `m_ready` is low on that cycle, the new packet is dropped, `overflow` pulses, and the old packet is retained.
  - `wcnt` returns to 0 in both cases.
- **Handshake:** the transfer occurs on a cycle with `m_valid && m_ready`. `m_data` is held stable while `m_valid && !m_ready`.
  - If a completion and a transfer fall on the same cycle, the new packet is loaded and `m_valid` stays high.
- **Timeout:** while in IDLE with `wcnt!=0`, count idle bit-times. After `TIMEOUT_PULSES` of them, clear `wcnt`. No error pulse is raised.
- **Reset:** `rst` at any time, including mid-frame, returns the FSM to IDLE and clears `wcnt` and the buffer. Outputs reset to `m_data=0`, `m_valid=0`, `frame_err=0`, `parity_err=0`, `overflow=0`, `busy=0`.

## Timing
- The synchronizer adds 2 cycles of latency. Let t0 be the first edge on which `rx_s==0` is seen in IDLE.
- The start sample is at t0 + `CLOCKS_PER_PULSE/2`. The data bit k sample is at t0 + `CLOCKS_PER_PULSE/2` + (k+1)·`CLOCKS_PER_PULSE`.
- Let `F = 1 + BITS_PER_WORD + (PARITY!=PAR_NONE) + STOP_BITS`. The last stop sample is at t0 + `CLOCKS_PER_PULSE/2` + (F-1)·`CLOCKS_PER_PULSE`.
- `m_valid`, `frame_err`, `parity_err` and `overflow` assert 1 cycle after the final stop sample.
- The FSM is back in IDLE 1 cycle after the final stop sample, which leaves half a bit of margin before the next start edge.
- Back-to-back frames with zero idle time must be received.

## Structure
- Package `uart_pkg` holds:
  - the `parity_e` typedef (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`);
  - the `rx_state_e` FSM enum;
  - the helper function `frame_bits(BITS_PER_WORD, PARITY, STOP_BITS)`.
- Sub-module `sync_2ff` implements the synchronizer and is reused by other blocks. Everything else is flat in `uart_rx_packer`.

## Test plan
- **Default 8N1, 3 words:** send 0x3C, 0xA5, 0x0F, keeping `m_ready` high → `m_data=24'h0FA53C`, one `m_valid` pulse at t0(word0) + 16 + 9·32 + 1 relative to the last word's t0.
- **Even parity:** send 0x81 with a wrong parity bit (0x81 has even data parity, so correct p=0; send p=1), then three good frames → `parity_err` pulse, partial packet discarded. The three good frames then form a packet.
- **Framing error:** hold the stop bit low, then hold `rx` low for 5 bit-times → one `frame_err` pulse, FSM stays in BREAK (`busy=1`) until `rx` rises, and no false start is detected.
- **Backpressure:** hold `m_ready=0` and send two full packets → first packet held stable, `overflow` pulses once, and after `m_ready=1` the first packet is transferred.
- **Glitch and timeout:** a low pulse of `CLOCKS_PER_PULSE/4` cycles gives no error and no word. With `TIMEOUT_PULSES=4`, sending 1 word then idling 5 bit-times clears `wcnt`, and the next 3 words form a clean packet.
- **Reset mid-frame:** assert `rst` during DATA bit 3 → all outputs 0 next cycle, and a subsequent clean packet is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and helpers for the UART receive path.
//   parity_e    : parity mode selector for receivers
//   rx_state_e  : receiver FSM states
//   frame_bits  : total bits in one UART frame, start bit included
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Start bit + data bits + optional parity bit + stop bits.
  function automatic int frame_bits(input int bits_per_word, input parity_e parity,
                                    input int stop_bits);
    return 1 + bits_per_word + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous level signal.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, loads RESET_VAL into both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output, two clk_i cycles of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // The first flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_packer.sv
// uart_rx_packer
// UART receiver that packs N_WORDS = W_OUT/BITS_PER_WORD received words into one
// output packet delivered on a valid/ready handshake.
//   clk        : single clock
//   rst        : synchronous active-high reset
//   rx         : asynchronous serial line, idle high
//   m_data     : packet, word 0 (first received) in the low bits
//   m_valid    : packet available, held until m_ready
//   m_ready    : consumer accepts the packet
//   frame_err  : one-cycle pulse, a stop bit was sampled low
//   parity_err : one-cycle pulse, parity mismatch on the word just ended
//   overflow   : one-cycle pulse, a completed packet was dropped (output full)
//   busy       : receiver FSM is not idle
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int      CLOCKS_PER_PULSE = 32,
  parameter int      BITS_PER_WORD    = 8,
  parameter int      W_OUT            = 24,
  parameter parity_e PARITY           = PAR_NONE,
  parameter int      STOP_BITS        = 1,
  parameter int      TIMEOUT_PULSES   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [W_OUT-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overflow,
  output logic             busy
);

  localparam int N_WORDS    = W_OUT / BITS_PER_WORD;
  localparam int PCNT_W     = $clog2(CLOCKS_PER_PULSE);
  localparam int WCNT_W     = $clog2(N_WORDS + 1);
  localparam int FIDX_W     = 4;
  localparam int FRAME_BITS = frame_bits(BITS_PER_WORD, PARITY, STOP_BITS);
  localparam int TO_LAST    = (TIMEOUT_PULSES > 0) ? TIMEOUT_PULSES - 1 : 0;
  localparam bit TO_EN      = (TIMEOUT_PULSES > 0);

  localparam logic [PCNT_W-1:0] HALF_LAST = PCNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [PCNT_W-1:0] BIT_LAST  = PCNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [FIDX_W-1:0] DATA_LAST = FIDX_W'(BITS_PER_WORD);
  localparam logic [FIDX_W-1:0] STOP_LAST = FIDX_W'(FRAME_BITS - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(N_WORDS - 1);
  localparam logic [15:0]       TO_LAST_W = 16'(TO_LAST);

  logic                     rx_s;
  rx_state_e                state_q;
  logic [PCNT_W-1:0]        pcnt_q;
  logic [FIDX_W-1:0]        fidx_q;
  logic [BITS_PER_WORD-1:0] shift_q;
  logic                     word_bad_q;
  logic [WCNT_W-1:0]        wcnt_q;
  logic [W_OUT-1:0]         buf_q;
  logic [15:0]              tocnt_q;
  logic [W_OUT-1:0]         m_data_q;
  logic                     m_valid_q;
  logic                     frame_err_q;
  logic                     parity_err_q;
  logic                     overflow_q;

  logic [W_OUT-1:0]         packet_d;
  logic                     par_bad_d;

  // Idle-high reset value keeps a freshly reset receiver from seeing a false start.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  // Assembly buffer with the word just received dropped into slot wcnt.
  always_comb begin
    packet_d = buf_q;
    for (int i = 0; i < N_WORDS; i++) begin
      if (wcnt_q == WCNT_W'(i)) begin
        packet_d[i*BITS_PER_WORD +: BITS_PER_WORD] = shift_q;
      end
    end
  end

  // Parity check of the full word against the parity bit now on the line.
  always_comb begin
    par_bad_d = 1'b0;
    if (PARITY == PAR_ODD) begin
      par_bad_d = ~(^{shift_q, rx_s});
    end else if (PARITY == PAR_EVEN) begin
      par_bad_d = ^{shift_q, rx_s};
    end
  end

  // Receiver FSM, word packer, output handshake and idle timeout.
  // fidx_q numbers the samples of a frame (start = 0), so the last stop sample
  // is simply sample FRAME_BITS-1. Error and completion results are registered
  // on the final stop sample, so they appear together with the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pcnt_q       <= '0;
      fidx_q       <= '0;
      shift_q      <= '0;
      word_bad_q   <= 1'b0;
      wcnt_q       <= '0;
      buf_q        <= '0;
      tocnt_q      <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;

      // A completion later in this block overrides the clear, so a packet
      // arriving on a transfer cycle keeps m_valid high.
      if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_START;
            pcnt_q  <= '0;
            tocnt_q <= '0;
          end else if (TO_EN && (wcnt_q != '0)) begin
            if (pcnt_q == BIT_LAST) begin
              pcnt_q <= '0;
              if (tocnt_q == TO_LAST_W) begin
                wcnt_q  <= '0;
                tocnt_q <= '0;
              end else begin
                tocnt_q <= tocnt_q + 1'b1;
              end
            end else begin
              pcnt_q <= pcnt_q + 1'b1;
            end
          end else begin
            pcnt_q  <= '0;
            tocnt_q <= '0;
          end
        end

        ST_START: begin
          if (pcnt_q == HALF_LAST) begin
            pcnt_q <= '0;
            if (rx_s) begin
              state_q <= ST_IDLE;
            end else begin
              state_q    <= ST_DATA;
              fidx_q     <= FIDX_W'(1);
              word_bad_q <= 1'b0;
            end
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end

        ST_DATA, ST_PARITY, ST_STOP: begin
          if (pcnt_q != BIT_LAST) begin
            pcnt_q <= pcnt_q + 1'b1;
          end else begin
            pcnt_q <= '0;
            fidx_q <= fidx_q + 1'b1;
            if (state_q == ST_DATA) begin
              shift_q <= {rx_s, shift_q[BITS_PER_WORD-1:1]};
              if (fidx_q == DATA_LAST) begin
                state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              end
            end else if (state_q == ST_PARITY) begin
              word_bad_q <= par_bad_d;
              state_q    <= ST_STOP;
            end else if (!rx_s) begin
              frame_err_q  <= 1'b1;
              parity_err_q <= word_bad_q;
              wcnt_q       <= '0;
              state_q      <= ST_BREAK;
            end else if (fidx_q == STOP_LAST) begin
              state_q      <= ST_IDLE;
              parity_err_q <= word_bad_q;
              if (word_bad_q) begin
                wcnt_q <= '0;
              end else if (wcnt_q == WCNT_LAST) begin
                wcnt_q <= '0;
                if (m_valid_q && !m_ready) begin
                  overflow_q <= 1'b1;
                end else begin
                  m_data_q  <= packet_d;
                  m_valid_q <= 1'b1;
                end
              end else begin
                buf_q  <= packet_d;
                wcnt_q <= wcnt_q + 1'b1;
              end
            end
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_packer.sv
// tb_uart_rx_packer
// Directed bench for uart_rx_packer. dutA uses the default 8N1 setup, dutB uses
// even parity with a 4 bit-time idle timeout. Each has its own rx line.
module tb_uart_rx_packer;

  localparam int CPP = 32;

  logic        clk;
  logic        rst;
  logic        rxA, rxB;
  logic        mReadyA, mReadyB;
  logic [23:0] mDataA, mDataB;
  logic        mValidA, mValidB;
  logic        frameErrA, frameErrB;
  logic        parityErrA, parityErrB;
  logic        overflowA, overflowB;
  logic        busyA, busyB;

  int cyc = 0;
  int checkCount = 0;
  int passCount = 0;
  int lastStartCyc = 0;

  int xferA = 0, xferB = 0;
  int lastXferCycA = 0;
  logic [23:0] lastDataA = '0, lastDataB = '0;
  int frameErrCntA = 0, frameErrCntB = 0;
  int parErrCntA = 0, parErrCntB = 0;
  int ovfCntA = 0;

  uart_rx_packer #(
    .CLOCKS_PER_PULSE(CPP)
  ) dutA (
    .clk       (clk),
    .rst       (rst),
    .rx        (rxA),
    .m_data    (mDataA),
    .m_valid   (mValidA),
    .m_ready   (mReadyA),
    .frame_err (frameErrA),
    .parity_err(parityErrA),
    .overflow  (overflowA),
    .busy      (busyA)
  );

  uart_rx_packer #(
    .CLOCKS_PER_PULSE(CPP),
    .PARITY          (uart_pkg::PAR_EVEN),
    .TIMEOUT_PULSES  (4)
  ) dutB (
    .clk       (clk),
    .rst       (rst),
    .rx        (rxB),
    .m_data    (mDataB),
    .m_valid   (mValidB),
    .m_ready   (mReadyB),
    .frame_err (frameErrB),
    .parity_err(parityErrB),
    .overflow  (overflowB),
    .busy      (busyB)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Posedge counter used to timestamp frames and transfers.
  always @(posedge clk) begin
    cyc++;
  end

  // Scoreboard of transfers and pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mValidA && mReadyA) begin
        xferA++;
        lastDataA = mDataA;
        lastXferCycA = cyc;
      end
      if (mValidB && mReadyB) begin
        xferB++;
        lastDataB = mDataB;
      end
      if (frameErrA)  frameErrCntA++;
      if (frameErrB)  frameErrCntB++;
      if (parityErrA) parErrCntA++;
      if (parityErrB) parErrCntB++;
      if (overflowA)  ovfCntA++;
    end
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    repeat (100000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout expected sequence end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setLine(input int sel, input logic val);
    if (sel == 0) rxA = val;
    else          rxB = val;
  endtask

  task automatic driveBit(input int sel, input logic val);
    setLine(sel, val);
    waitCycles(CPP);
  endtask

  // One full frame, LSB first, starting right away (back-to-back capable).
  task automatic applyStimulus(input int sel, input logic [7:0] data, input bit withPar,
                               input logic parBit, input logic stopVal);
    lastStartCyc = cyc;
    driveBit(sel, 1'b0);
    for (int k = 0; k < 8; k++) driveBit(sel, data[k]);
    if (withPar) driveBit(sel, parBit);
    driveBit(sel, stopVal);
  endtask

  int t3;

  initial begin
    rst = 1'b1;
    rxA = 1'b1;
    rxB = 1'b1;
    mReadyA = 1'b1;
    mReadyB = 1'b1;
    waitCycles(4);
    @(negedge clk);
    checkOutput("reset m_data",     32'(mDataA),     32'h0);
    checkOutput("reset m_valid",    32'(mValidA),    32'h0);
    checkOutput("reset busy",       32'(busyA),      32'h0);
    checkOutput("reset frame_err",  32'(frameErrA),  32'h0);
    checkOutput("reset parity_err", 32'(parityErrA), 32'h0);
    checkOutput("reset overflow",   32'(overflowA),  32'h0);
    waitCycles(1);
    rst = 1'b0;
    waitCycles(2 * CPP);

    // 8N1, three back-to-back words. Transfer seen 2 sync + 1 detect + 16 + 9*32 = 307 cycles after last start.
    $display("[TB] 8N1 packet");
    applyStimulus(0, 8'h3C, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'hA5, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'h0F, 0, 1'b0, 1'b1);
    t3 = lastStartCyc;
    waitCycles(2 * CPP);
    checkOutput("8n1 xfer count", xferA, 1);
    checkOutput("8n1 data",       32'(lastDataA), 32'h000FA53C);
    checkOutput("8n1 valid time", lastXferCycA - t3, 307);

    // One good word, then a frame with its stop bit low and the line held low.
    $display("[TB] framing error and break");
    applyStimulus(0, 8'h99, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'h5A, 0, 1'b0, 1'b0);
    setLine(0, 1'b0);
    waitCycles(5 * CPP);
    @(negedge clk);
    checkOutput("break frame_err count", frameErrCntA, 1);
    checkOutput("break busy",            32'(busyA), 32'h1);
    waitCycles(1);
    setLine(0, 1'b1);
    waitCycles(2 * CPP);
    checkOutput("break released busy",  32'(busyA), 32'h0);
    checkOutput("break no new frame",   frameErrCntA, 1);
    checkOutput("break no packet",      xferA, 1);

    // Short low glitch gives nothing; the discarded 0x99 must not reappear.
    $display("[TB] glitch");
    setLine(0, 1'b0);
    waitCycles(CPP / 4);
    setLine(0, 1'b1);
    waitCycles(2 * CPP);
    checkOutput("glitch busy",      32'(busyA), 32'h0);
    checkOutput("glitch frame_err", frameErrCntA, 1);
    checkOutput("glitch no packet", xferA, 1);
    applyStimulus(0, 8'h01, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'h02, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'h03, 0, 1'b0, 1'b1);
    waitCycles(CPP);
    checkOutput("after break xfer count", xferA, 2);
    checkOutput("after break data",       32'(lastDataA), 32'h00030201);

    // Backpressure: second packet overflows, first one is kept.
    $display("[TB] backpressure");
    mReadyA = 1'b0;
    applyStimulus(0, 8'h11, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'h22, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'h33, 0, 1'b0, 1'b1);
    waitCycles(CPP);
    checkOutput("bp valid held", 32'(mValidA), 32'h1);
    checkOutput("bp data",       32'(mDataA),  32'h00332211);
    checkOutput("bp no xfer",    xferA, 2);
    applyStimulus(0, 8'h44, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'h55, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'h66, 0, 1'b0, 1'b1);
    waitCycles(CPP);
    checkOutput("bp overflow count", ovfCntA, 1);
    checkOutput("bp data stable",    32'(mDataA), 32'h00332211);
    checkOutput("bp valid still",    32'(mValidA), 32'h1);
    mReadyA = 1'b1;
    waitCycles(4);
    checkOutput("bp released xfer",  xferA, 3);
    checkOutput("bp released data",  32'(lastDataA), 32'h00332211);
    checkOutput("bp valid dropped",  32'(mValidA), 32'h0);

    // Reset in the middle of data bit 3 while a packet is pending.
    $display("[TB] reset mid-frame");
    mReadyA = 1'b0;
    applyStimulus(0, 8'hAA, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'hBB, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'hCC, 0, 1'b0, 1'b1);
    waitCycles(CPP);
    checkOutput("pre-reset valid", 32'(mValidA), 32'h1);
    driveBit(0, 1'b0);
    driveBit(0, 1'b0);
    driveBit(0, 1'b1);
    driveBit(0, 1'b0);
    setLine(0, 1'b1);
    waitCycles(CPP / 2);
    rst = 1'b1;
    waitCycles(1);
    @(negedge clk);
    checkOutput("midrst m_valid", 32'(mValidA), 32'h0);
    checkOutput("midrst m_data",  32'(mDataA),  32'h0);
    checkOutput("midrst busy",    32'(busyA),   32'h0);
    waitCycles(1);
    rst = 1'b0;
    mReadyA = 1'b1;
    waitCycles(2 * CPP);
    applyStimulus(0, 8'hDE, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'hAD, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'hBE, 0, 1'b0, 1'b1);
    waitCycles(CPP);
    checkOutput("post-reset xfer count", xferA, 4);
    checkOutput("post-reset data",       32'(lastDataA), 32'h00BEADDE);
    checkOutput("8n1 no parity_err",     parErrCntA, 0);

    // Even parity: good 0x99 (p=0), bad 0x81 (p=1 sent, 0 needed), then 0x11 p0, 0x22 p0, 0x07 p1.
    $display("[TB] even parity");
    applyStimulus(1, 8'h99, 1, 1'b0, 1'b1);
    applyStimulus(1, 8'h81, 1, 1'b1, 1'b1);
    waitCycles(4);
    checkOutput("parity_err count", parErrCntB, 1);
    applyStimulus(1, 8'h11, 1, 1'b0, 1'b1);
    applyStimulus(1, 8'h22, 1, 1'b0, 1'b1);
    applyStimulus(1, 8'h07, 1, 1'b1, 1'b1);
    waitCycles(CPP);
    checkOutput("parity xfer count",  xferB, 1);
    checkOutput("parity data",        32'(lastDataB), 32'h00072211);
    checkOutput("parity single err",  parErrCntB, 1);
    checkOutput("parity no frame_err", frameErrCntB, 0);

    // Timeout: 0x55 (p0) then 5 idle bit-times drops it; 0x12 p0, 0x34 p1, 0x56 p0 follow.
    $display("[TB] idle timeout");
    applyStimulus(1, 8'h55, 1, 1'b0, 1'b1);
    waitCycles(5 * CPP);
    applyStimulus(1, 8'h12, 1, 1'b0, 1'b1);
    applyStimulus(1, 8'h34, 1, 1'b1, 1'b1);
    applyStimulus(1, 8'h56, 1, 1'b0, 1'b1);
    waitCycles(CPP);
    checkOutput("timeout xfer count", xferB, 2);
    checkOutput("timeout data",       32'(lastDataB), 32'h00563412);
    checkOutput("timeout no errors",  parErrCntB + frameErrCntB, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
